mat_operand_feeder: RTL and testbench

MAT_OPERAND_FEEDER -- requirements
Module: mat_operand_feeder

---
 rtl/mat_operand_feeder.sv | 162 ++++++++++++++++
 tb/tb_mat_operand_feeder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mat_operand_feeder.sv
// Loads two WIDTH x WIDTH operand matrices and steps a downstream MAC stage through every (r, c).
// It captures each partial sum after HOLD cycles and streams the results out in row-major order.
module mat_operand_feeder #(
  parameter int BITS  = 24,
  parameter int WIDTH = 3,
  parameter int HOLD  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BITS-1:0]         in_data,
  output logic [WIDTH*BITS-1:0]   row_o,
  output logic [WIDTH*BITS-1:0]   col_o,
  output logic                    mac_rst_n,
  input  logic [2*BITS-1:0]       mac_res_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*BITS-1:0]       out_data,
  output logic [3:0]              out_row,
  output logic [3:0]              out_col,
  output logic                    busy,
  output logic                    done
);

  localparam int N  = WIDTH * WIDTH;
  localparam int KW = $clog2(N);
  localparam int HW = $clog2(HOLD);
  localparam logic [KW-1:0] K_LAST   = KW'(N - 1);
  localparam logic [HW-1:0] CNT_LAST = HW'(HOLD - 1);
  localparam logic [3:0]    IDX_LAST = 4'(WIDTH - 1);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, ISSUE, WAIT, OUT, DONE} state_t;

  state_t              state_q;
  logic [KW-1:0]       k_q;
  logic [3:0]          r_q;
  logic [3:0]          c_q;
  logic [HW-1:0]       cnt_q;
  logic                mac_rst_n_q;
  logic                out_valid_q;
  logic                done_q;
  logic [2*BITS-1:0]   out_data_q;
  logic [3:0]          out_row_q;
  logic [3:0]          out_col_q;

  logic [BITS-1:0]     a_mem [N];
  logic [BITS-1:0]     b_mem [N];
  logic [BITS-1:0]     row_q [WIDTH];
  logic [BITS-1:0]     col_q [WIDTH];
  logic [KW-1:0]       a_idx [WIDTH];
  logic [KW-1:0]       b_idx [WIDTH];

  // Gated by reset so the load port is closed while reset is held, yet open on the first cycle after release.
  assign in_ready  = reset && (state_q == LOAD_A || state_q == LOAD_B);
  assign busy      = !(state_q == LOAD_A && k_q == '0);
  assign mac_rst_n = mac_rst_n_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      if (state_q == LOAD_A) a_mem[k_q] <= in_data;
      else                   b_mem[k_q] <= in_data;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    assign a_idx[gi] = KW'(int'(r_q) * WIDTH + gi);
    assign b_idx[gi] = KW'(gi * WIDTH + int'(c_q));
    assign row_o[gi*BITS +: BITS] = row_q[gi];
    assign col_o[gi*BITS +: BITS] = col_q[gi];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD_A;
      k_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      mac_rst_n_q <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      for (int j = 0; j < WIDTH; j++) begin
        row_q[j] <= '0;
        col_q[j] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        LOAD_A: if (in_valid) begin
          if (k_q == K_LAST) begin
            k_q     <= '0;
            state_q <= LOAD_B;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        LOAD_B: if (in_valid) begin
          if (k_q == K_LAST) begin
            k_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            state_q <= ISSUE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        ISSUE: begin
          for (int j = 0; j < WIDTH; j++) begin
            row_q[j] <= a_mem[a_idx[j]];
            col_q[j] <= b_mem[b_idx[j]];
          end
          mac_rst_n_q <= 1'b1;
          cnt_q       <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + HW'(1);
          if (cnt_q == CNT_LAST) begin
            out_data_q  <= mac_res_i;
            out_row_q   <= r_q;
            out_col_q   <= c_q;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          mac_rst_n_q <= 1'b0;
          if (c_q == IDX_LAST) begin
            c_q <= '0;
            if (r_q == IDX_LAST) begin
              r_q     <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              r_q     <= r_q + 4'd1;
              state_q <= ISSUE;
            end
          end else begin
            c_q     <= c_q + 4'd1;
            state_q <= ISSUE;
          end
        end
        DONE: begin
          k_q     <= '0;
          state_q <= LOAD_A;
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_operand_feeder.sv
// Directed bench for mat_operand_feeder with a behavioural MAC stage (or a constant stub) on the MAC port.
module tb_mat_operand_feeder;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [23:0]  in_data;
  logic [71:0]  row_o;
  logic [71:0]  col_o;
  logic         mac_rst_n;
  logic [47:0]  mac_res_i;
  logic         out_valid;
  logic         out_ready;
  logic [47:0]  out_data;
  logic [3:0]   out_row;
  logic [3:0]   out_col;
  logic         busy;
  logic         done;

  mat_operand_feeder #(.BITS(24), .WIDTH(3), .HOLD(6)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .row_o(row_o), .col_o(col_o), .mac_rst_n(mac_rst_n), .mac_res_i(mac_res_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int done_cnt = 0;
  int hs_cnt   = 0;
  bit stub = 1'b0;

  logic [47:0] mul_tab [9] = '{48'd30, 48'd36, 48'd42, 48'd66, 48'd81, 48'd96, 48'd102, 48'd126, 48'd150};

  // Downstream MAC: accumulates one lane per cycle once released from its restart.
  logic [47:0] acc;
  int mj;
  always @(posedge clk) begin
    if (!mac_rst_n) begin
      acc <= '0;
      mj  <= 0;
    end else if (mj < 3) begin
      acc <= acc + 48'(row_o[mj*24 +: 24]) * 48'(col_o[mj*24 +: 24]);
      mj  <= mj + 1;
    end
  end
  assign mac_res_i = stub ? 48'hFFFF_FFFF_FFFF : acc;

  always @(posedge clk) begin
    if (done) done_cnt++;
    if (out_valid && out_ready) hs_cnt++;
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] exp_val(input int mode, input int i);
    if (mode == 0) return 48'(i + 1);
    if (mode == 1) return mul_tab[i];
    return 48'hFFFF_FFFF_FFFF;
  endfunction

  // A = 1..9 row-major; B = identity or 1..9. Optional idle beat before each beat.
  task automatic load(input bit ident, input bit gap);
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 9; k++) begin
        if (gap) begin
          in_valid = 1'b0;
          in_data  = 24'hABCDEF;
          @(negedge clk);
        end
        in_valid = 1'b1;
        if (m == 1 && ident) in_data = 24'((k % 4 == 0) ? 1 : 0);
        else                 in_data = 24'(k + 1);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    chk("busy_issue", busy, 1);
    chk("rdy_issue", in_ready, 0);
    chk("macrst_issue", mac_rst_n, 0);
  endtask

  // Entered on the negedge of an ISSUE cycle; leaves on the negedge after the handshake.
  task automatic get_result(input int i, input logic [47:0] e, input bit stall);
    int t;
    t = 0;
    if (stall) out_ready = 1'b0;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("lat%0d", i), t, 7);
    chk($sformatf("data%0d", i), out_data, e);
    chk($sformatf("row%0d", i), out_row, i / 3);
    chk($sformatf("col%0d", i), out_col, i % 3);
    chk($sformatf("rdy_out%0d", i), in_ready, 0);
    $display("result %0d: r=%0d c=%0d data=%0h latency=%0d", i, out_row, out_col, out_data, t);
    if (stall) begin
      for (int s = 0; s < 5; s++) begin
        @(negedge clk);
        chk($sformatf("hold_vld%0d", s), out_valid, 1);
        chk($sformatf("hold_data%0d", s), out_data, e);
        chk($sformatf("hold_col%0d", s), out_col, i % 3);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("drop%0d", i), out_valid, 0);
  endtask

  task automatic run_op(input int mode, input bit gap, input int stall_idx);
    int d0, h0;
    d0   = done_cnt;
    h0   = hs_cnt;
    stub = (mode == 2);
    load(mode != 1, gap);
    for (int i = 0; i < 9; i++) begin
      get_result(i, exp_val(mode, i), i == stall_idx);
      if (mode == 1 && i == 5) begin
        chk("row_o_12", row_o, {24'd6, 24'd5, 24'd4});
        chk("col_o_12", col_o, {24'd9, 24'd6, 24'd3});
      end
    end
    chk("done_hi", done, 1);
    chk("busy_done", busy, 1);
    @(negedge clk);
    chk("done_lo", done, 0);
    chk("busy_idle", busy, 0);
    chk("rdy_idle", in_ready, 1);
    chk("done_pulses", done_cnt - d0, 1);
    chk("beats", hs_cnt - h0, 9);
    $display("operation mode=%0d gap=%0d stall=%0d finished", mode, gap, stall_idx);
  endtask

  initial begin
    int d0, h0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1 reset  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdy", in_ready, 0);
    chk("rst_macrst", mac_rst_n, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_row", row_o, 0);
    chk("rst_outdata", out_data, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_rdy", in_ready, 1);
    chk("rel_busy", busy, 0);
    @(negedge clk);

    run_op(0, 1'b0, -1);
    run_op(1, 1'b0, -1);
    run_op(1, 1'b1, -1);
    run_op(1, 1'b0, 1);

    // Abort during WAIT of (1,1), then reload.
    d0   = done_cnt;
    h0   = hs_cnt;
    stub = 1'b0;
    load(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) get_result(i, mul_tab[i], 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ab_rdy", in_ready, 0);
    chk("ab_macrst", mac_rst_n, 0);
    chk("ab_vld", out_valid, 0);
    chk("ab_done", done, 0);
    chk("ab_busy", busy, 0);
    chk("ab_row", row_o, 0);
    chk("ab_colo", col_o, 0);
    chk("ab_data", out_data, 0);
    chk("ab_orow", out_row, 0);
    chk("ab_ocol", out_col, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ab_rel_rdy", in_ready, 1);
    repeat (3) @(negedge clk);
    chk("ab_idle_vld", out_valid, 0);
    chk("ab_beats", hs_cnt - h0, 4);
    chk("ab_no_done", done_cnt - d0, 0);
    $display("abort during WAIT of (1,1) handled");
    run_op(1, 1'b0, -1);

    run_op(2, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
